// File: rtl/tdt_dmi_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : tdt_dmi_pkg
//  Purpose  : Shared definitions for the DMI req/ack CDC receiver: FSM state
//             encoding and default payload / counter widths.
//  Revision : 1.0  initial release
// ============================================================================
package tdt_dmi_pkg;

   // 2'b11 is deliberately left unencoded; the FSM treats it as illegal
   // and falls back to ST_IDLE.
   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_VALID = 2'b01,
      ST_ACK   = 2'b10
   } rcv_state_t;

   localparam int DATA_W_DEF = 32;
   localparam int CNT_W_DEF  = 8;

endpackage : tdt_dmi_pkg
`default_nettype wire

// File: rtl/tdt_dmi_req_rcv.sv
`default_nettype none
// ============================================================================
//  Module   : tdt_dmi_req_rcv
//  Purpose  : Destination side of a 4-phase req/ack CDC handshake on the DMI
//             path. Captures the source-held payload when the synchronized
//             request rises, offers it as a valid/ready transfer, then
//             returns a registered ack level to the source domain.
//  Ports    :
//    dst_clk   in   destination clock (only clock)
//    dst_rst   in   asynchronous active-high reset
//    req_sync  in   request level, already synchronized into dst_clk
//    src_data  in   payload, held stable by the source until ack is seen
//    dst_vld   out  payload valid toward the local consumer
//    dst_data  out  captured payload
//    dst_rdy   in   consumer accept (only meaningful while dst_vld=1)
//    ack_out   out  registered ack level toward the source synchronizer
//    busy      out  FSM is not idle
//    err_drop  out  one-cycle pulse: request withdrawn before acceptance
//    xfer_cnt  out  completed-transfer count, wraps silently
//  Revision : 1.0  initial release
// ============================================================================
module tdt_dmi_req_rcv
   import tdt_dmi_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int CNT_W  = CNT_W_DEF
) (
   input  logic              dst_clk,
   input  logic              dst_rst,
   input  logic              req_sync,
   input  logic [DATA_W-1:0] src_data,
   output logic              dst_vld,
   output logic [DATA_W-1:0] dst_data,
   input  logic              dst_rdy,
   output logic              ack_out,
   output logic              busy,
   output logic              err_drop,
   output logic [CNT_W-1:0]  xfer_cnt
);

   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   rcv_state_t state;
   rcv_state_t state_nxt;
   logic       vld_nxt;
   logic       ack_nxt;
   logic       err_nxt;
   logic       capture;
   logic       cnt_inc;

   // ------------------------------------------------------------------
   // Next-state and next-output decode. Every output is a flop, so this
   // block computes the value each output takes after the coming edge.
   // ------------------------------------------------------------------
   always_comb begin
      state_nxt = state;
      vld_nxt   = 1'b0;
      ack_nxt   = 1'b0;
      err_nxt   = 1'b0;
      capture   = 1'b0;
      cnt_inc   = 1'b0;
      case (state)
         ST_IDLE: begin
            if (req_sync) begin
               state_nxt = ST_VALID;
               vld_nxt   = 1'b1;
               capture   = 1'b1;
            end
         end
         ST_VALID: begin
            // A withdrawn request takes priority over a same-cycle accept:
            // the source no longer guarantees the payload, so nothing is
            // acknowledged or counted.
            if (!req_sync) begin
               state_nxt = ST_IDLE;
               err_nxt   = 1'b1;
            end else if (dst_rdy) begin
               state_nxt = ST_ACK;
               ack_nxt   = 1'b1;
               cnt_inc   = 1'b1;
            end else begin
               vld_nxt   = 1'b1;
            end
         end
         ST_ACK: begin
            // No timeout: wait for the source to drop its request.
            if (!req_sync) begin
               state_nxt = ST_IDLE;
            end else begin
               ack_nxt   = 1'b1;
            end
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // State and output registers.
   // ------------------------------------------------------------------
   always_ff @(posedge dst_clk or posedge dst_rst) begin
      if (dst_rst) begin
         state    <= ST_IDLE;
         dst_vld  <= 1'b0;
         dst_data <= '0;
         ack_out  <= 1'b0;
         busy     <= 1'b0;
         err_drop <= 1'b0;
         xfer_cnt <= '0;
      end else begin
         state    <= state_nxt;
         dst_vld  <= vld_nxt;
         ack_out  <= ack_nxt;
         busy     <= (state_nxt != ST_IDLE);
         err_drop <= err_nxt;
         if (capture) begin
            dst_data <= src_data;
         end
         if (cnt_inc) begin
            xfer_cnt <= xfer_cnt + CNT_ONE;
         end
      end
   end

endmodule : tdt_dmi_req_rcv
`default_nettype wire

// File: tb/tb_tdt_dmi_req_rcv.sv
`default_nettype none
// ============================================================================
//  Module   : tb_tdt_dmi_req_rcv
//  Purpose  : Self-checking bench for tdt_dmi_req_rcv. Payloads are queued
//             when the request is raised and compared in order when the
//             consumer handshake completes.
//  Revision : 1.0  initial release
// ============================================================================
module tb_tdt_dmi_req_rcv;

   localparam int DATA_W = 32;
   localparam int CNT_W  = 8;

   logic              dst_clk;
   logic              dst_rst;
   logic              req_sync;
   logic [DATA_W-1:0] src_data;
   logic              dst_vld;
   logic [DATA_W-1:0] dst_data;
   logic              dst_rdy;
   logic              ack_out;
   logic              busy;
   logic              err_drop;
   logic [CNT_W-1:0]  xfer_cnt;

   int                n_vec;
   int                n_err;
   logic [DATA_W-1:0] sb_q[$];
   logic [CNT_W-1:0]  exp_cnt;
   logic [DATA_W-1:0] held;

   tdt_dmi_req_rcv #(
      .DATA_W (DATA_W),
      .CNT_W  (CNT_W)
   ) u_dut (
      .dst_clk  (dst_clk),
      .dst_rst  (dst_rst),
      .req_sync (req_sync),
      .src_data (src_data),
      .dst_vld  (dst_vld),
      .dst_data (dst_data),
      .dst_rdy  (dst_rdy),
      .ack_out  (ack_out),
      .busy     (busy),
      .err_drop (err_drop),
      .xfer_cnt (xfer_cnt)
   );

   initial dst_clk = 1'b0;
   always #5 dst_clk = ~dst_clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // Advance one clock; inputs are driven and outputs sampled 1 time unit
   // after the rising edge.
   task automatic tick();
      @(posedge dst_clk);
      #1;
   endtask

   // Consumer handshake observed: the payload at the head of the
   // scoreboard must be the one on dst_data.
   task automatic sb_pop_check(input string tag);
      if (sb_q.size() == 0) begin
         chk({tag, "_sb_empty"}, 64'd0, 64'd1);
      end else begin
         chk(tag, dst_data, sb_q.pop_front());
      end
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, "_vld"},  dst_vld,  0);
      chk({tag, "_data"}, dst_data, 0);
      chk({tag, "_ack"},  ack_out,  0);
      chk({tag, "_busy"}, busy,     0);
      chk({tag, "_err"},  err_drop, 0);
      chk({tag, "_cnt"},  xfer_cnt, 0);
   endtask

   // Reset asserted mid-cycle, checked before the next clock edge, then
   // released away from the edge.
   task automatic async_reset(input string tag);
      #2;
      dst_rst = 1'b1;
      #1;
      check_all_zero(tag);
      exp_cnt = '0;
      sb_q.delete();
      dst_rdy = 1'b0;
      #2;
      dst_rst = 1'b0;
   endtask

   // One transfer at minimum spacing: req high for two edges, low for one.
   task automatic b2b_xfer(input logic [DATA_W-1:0] d);
      req_sync = 1'b1;
      src_data = d;
      sb_q.push_back(d);
      tick();
      chk("b2b_vld", dst_vld, 1);
      if (dst_vld && dst_rdy) sb_pop_check("b2b_data");
      tick();
      exp_cnt = exp_cnt + 1'b1;
      chk("b2b_ack", ack_out, 1);
      chk("b2b_cnt", xfer_cnt, exp_cnt);
      req_sync = 1'b0;
      tick();
      chk("b2b_ack_rel", ack_out, 0);
   endtask

   initial begin
      n_vec    = 0;
      n_err    = 0;
      exp_cnt  = '0;
      dst_rst  = 1'b1;
      req_sync = 1'b0;
      src_data = '0;
      dst_rdy  = 1'b0;
      repeat (2) tick();
      check_all_zero("rst");
      dst_rst = 1'b0;
      tick();

      // ---------------- single transfer ----------------
      req_sync = 1'b1;
      src_data = 32'hDEADBEEF;
      dst_rdy  = 1'b1;
      sb_q.push_back(32'hDEADBEEF);
      tick();
      chk("single_vld", dst_vld, 1);
      chk("single_busy", busy, 1);
      chk("single_ack0", ack_out, 0);
      if (dst_vld && dst_rdy) sb_pop_check("single_data");
      tick();
      exp_cnt = exp_cnt + 1'b1;
      chk("single_vld_drop", dst_vld, 0);
      chk("single_ack", ack_out, 1);
      chk("single_cnt", xfer_cnt, exp_cnt);
      req_sync = 1'b0;
      tick();
      chk("single_ack_rel", ack_out, 0);
      chk("single_idle", busy, 0);

      // ---------------- consumer stall ----------------
      dst_rdy  = 1'b0;
      req_sync = 1'b1;
      src_data = 32'h12345678;
      held     = 32'h12345678;
      sb_q.push_back(held);
      tick();
      // Payload must not follow src_data once captured.
      src_data = 32'hA5A5A5A5;
      for (int i = 0; i < 10; i++) begin
         chk("stall_vld", dst_vld, 1);
         chk("stall_data", dst_data, held);
         chk("stall_ack", ack_out, 0);
         tick();
      end
      dst_rdy = 1'b1;
      if (dst_vld && dst_rdy) sb_pop_check("stall_data_acc");
      tick();
      exp_cnt = exp_cnt + 1'b1;
      chk("stall_ack1", ack_out, 1);
      chk("stall_cnt", xfer_cnt, exp_cnt);
      req_sync = 1'b0;
      tick();
      chk("stall_ack_rel", ack_out, 0);

      // ---------------- protocol violation, rdy=0 / rdy=1 ----------------
      for (int r = 0; r < 2; r++) begin
         dst_rdy  = 1'b0;
         req_sync = 1'b1;
         src_data = $urandom;
         tick();
         chk("viol_vld", dst_vld, 1);
         req_sync = 1'b0;
         dst_rdy  = (r == 1);
         tick();
         chk("viol_err", err_drop, 1);
         chk("viol_ack", ack_out, 0);
         chk("viol_vld0", dst_vld, 0);
         chk("viol_busy", busy, 0);
         chk("viol_cnt", xfer_cnt, exp_cnt);
         tick();
         chk("viol_err_pulse", err_drop, 0);
         chk("viol_ack_after", ack_out, 0);
         dst_rdy = 1'b0;
      end

      // ---------------- async reset in VALID ----------------
      req_sync = 1'b1;
      src_data = 32'hCAFEF00D;
      tick();
      chk("rv_vld", dst_vld, 1);
      async_reset("rst_valid");
      src_data = 32'h0BADC0DE;
      tick();
      chk("rv_recap_vld", dst_vld, 1);
      chk("rv_recap_data", dst_data, 32'h0BADC0DE);

      // ---------------- async reset in ACK ----------------
      dst_rdy = 1'b1;
      tick();
      chk("ra_ack", ack_out, 1);
      chk("ra_cnt", xfer_cnt, 1);
      async_reset("rst_ack");
      src_data = 32'h55AA33CC;
      tick();
      chk("ra_recap_vld", dst_vld, 1);
      chk("ra_recap_data", dst_data, 32'h55AA33CC);

      // Return to a clean idle with counter at zero.
      async_reset("rst_clean");
      req_sync = 1'b0;
      tick();
      check_all_zero("clean");

      // ---------------- back-to-back with counter wrap ----------------
      dst_rdy = 1'b1;
      for (int i = 0; i < 300; i++) begin
         b2b_xfer($urandom);
      end
      chk("wrap_cnt", xfer_cnt, 8'd44);
      chk("sb_drained", sb_q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule : tb_tdt_dmi_req_rcv
`default_nettype wire
